// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219/7221 frame protocol.
// Used by the receive-side emulator (max7219_rx) and the transmit-side driver.
package max7219_pkg;

    // A frame is 16 bits, sent MSB first. Bits 15:12 are don't-care,
    // 11:8 are the register address and 7:0 are the data byte.
    localparam int FRAME_BITS = 16;

    // Register address map
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    // Code-B font, segments A..G in bits 6..0 (DP is handled separately).
    // Entry n is the pattern for nibble n: 0-9, '-', 'E', 'H', 'L', 'P', blank.
    localparam logic [15:0][6:0] CODEB_SEG = {
        7'h00,  // F: blank
        7'h67,  // E: 'P'
        7'h0E,  // D: 'L'
        7'h37,  // C: 'H'
        7'h4F,  // B: 'E'
        7'h01,  // A: '-'
        7'h7B,  // 9
        7'h7F,  // 8
        7'h70,  // 7
        7'h5F,  // 6
        7'h5B,  // 5
        7'h33,  // 4
        7'h79,  // 3
        7'h6D,  // 2
        7'h30,  // 1
        7'h7E   // 0
    };

    // Outcome of a LOAD/CS rising edge
    typedef enum logic [1:0] {
        LATCH_NONE,
        LATCH_VALID,
        LATCH_ERR
    } latch_e;

    // The part of a frame that carries meaning
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

    // Code-B lookup of a digit byte; bit 7 (DP) passes through, bits 6:4 ignored
    function automatic logic [7:0] codeb_lookup(input logic [7:0] code);
        return {code[7], CODEB_SEG[code[3:0]]};
    endfunction

endpackage

// File: rtl/max7219_codeb_dec.sv
// Combinational digit-byte to segment-pattern decoder.
// With decode enabled the low nibble selects a Code-B glyph and DP passes
// through; otherwise the raw byte is the segment pattern (DP,A..G).
module max7219_codeb_dec
    import max7219_pkg::*;
(
    input  logic [7:0] code,
    input  logic       decode_en,
    output logic [7:0] seg
);

    // Select between font lookup and raw segment byte
    always_comb begin
        seg = code;
        if (decode_en) begin
            seg = codeb_lookup(code);
        end
    end

endmodule

// File: rtl/max7219_rx.sv
// MAX7219/7221 serial frame responder.
// Oversamples LOAD/CS, CLK and DIN on clk, deserialises 16-bit frames and
// applies them to a shadow register file exposed as parallel outputs.
// Optional macro MAX7219_RX_CODEB_EN: registered Code-B decode on seg_out;
// without it seg_out is a straight copy of digits.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cs,
    input  logic        s_sck,
    input  logic        s_din,
    output logic        s_dout,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  frame_addr,
    output logic [7:0]  frame_data,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic [63:0] seg_out
);

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] din_sync_reg;
    logic                   cs_prev_reg;
    logic                   sck_prev_reg;

    logic cs_s;
    logic sck_s;
    logic din_s;
    logic cs_rise;
    logic cs_fall;
    logic sck_rise;
    logic sck_fall;

    // Synchroniser chains; preset to the idle bus (CS high, SCK low)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_reg  <= '1;
            sck_sync_reg <= '0;
            din_sync_reg <= '0;
        end else begin
            cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], s_cs};
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], s_sck};
            din_sync_reg <= {din_sync_reg[SYNC_STAGES-2:0], s_din};
        end
    end

    assign cs_s  = cs_sync_reg[SYNC_STAGES-1];
    assign sck_s = sck_sync_reg[SYNC_STAGES-1];
    assign din_s = din_sync_reg[SYNC_STAGES-1];

    // One-cycle history of the synchronised CS and SCK for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_prev_reg  <= 1'b1;
            sck_prev_reg <= 1'b0;
        end else begin
            cs_prev_reg  <= cs_s;
            sck_prev_reg <= sck_s;
        end
    end

    assign cs_rise  =  cs_s  & ~cs_prev_reg;
    assign cs_fall  = ~cs_s  &  cs_prev_reg;
    assign sck_rise =  sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s &  sck_prev_reg;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [15:0]      sr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             dout_reg;
    logic             shift_en;
    latch_e           latch_kind;
    frame_t           wr_frame;
    logic             wr_en;

    // A CS rise drops any coincident SCK rise because CS is already high
    // in that cycle, so the latch always sees the bits shifted before it.
    assign shift_en = sck_rise & ~cs_s;

    // Classify a CS rising edge by how many bits the frame carried
    always_comb begin
        latch_kind = LATCH_NONE;
        if (cs_rise) begin
            if (cnt_reg >= CNT_W'(FRAME_BITS)) begin
                latch_kind = LATCH_VALID;
            end else if (cnt_reg != '0) begin
                latch_kind = LATCH_ERR;
            end
        end
    end

    // Bit counter: cleared on either CS edge, saturating increment per bit
    always_comb begin
        cnt_base = cnt_reg;
        if (cs_rise || cs_fall) begin
            cnt_base = '0;
        end
        cnt_next = cnt_base;
        if (shift_en && (cnt_base != '1)) begin
            cnt_next = cnt_base + 1'b1;
        end
    end

    // Shift register, counter and daisy-chain output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg   <= '0;
            cnt_reg  <= '0;
            dout_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (shift_en) begin
                sr_reg <= {sr_reg[14:0], din_s};
            end
            if (sck_fall && !cs_s) begin
                dout_reg <= sr_reg[15];
            end
        end
    end

    // Only the last 16 bits shifted in matter; bits 15:12 are don't-care
    assign wr_frame = sr_reg[11:0];
    assign wr_en    = (latch_kind == LATCH_VALID);

    // ------------------------------------------------------------------
    // Frame event outputs
    // ------------------------------------------------------------------
    logic       frame_valid_reg;
    logic       frame_err_reg;
    logic [3:0] frame_addr_reg;
    logic [7:0] frame_data_reg;

    // Pulses and last-frame capture, aligned with the register write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            frame_addr_reg  <= '0;
            frame_data_reg  <= '0;
        end else begin
            frame_valid_reg <= wr_en;
            frame_err_reg   <= (latch_kind == LATCH_ERR);
            if (wr_en) begin
                frame_addr_reg <= wr_frame.addr;
                frame_data_reg <= wr_frame.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow register file
    // ------------------------------------------------------------------
    logic [7:0] decode_reg;
    logic [3:0] intensity_reg;
    logic [2:0] scan_reg;
    logic       shutdown_reg;
    logic       test_reg;

    genvar gi;

    // Digit registers, one per address 0x1..0x8
    for (gi = 0; gi < 8; gi++) begin : g_digit
        logic [7:0] value_reg;

        // Capture the data byte when a valid frame targets this digit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                value_reg <= '0;
            end else if (wr_en && (wr_frame.addr == ADDR_DIGIT0 + 4'(gi))) begin
                value_reg <= wr_frame.data;
            end
        end

        assign digits[8*gi +: 8] = value_reg;
    end

    // Control registers; writes land even in shutdown or display-test mode
    // since those bits only report status here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decode_reg    <= '0;
            intensity_reg <= '0;
            scan_reg      <= '0;
            shutdown_reg  <= 1'b0;
            test_reg      <= 1'b0;
        end else if (wr_en) begin
            case (wr_frame.addr)
                ADDR_DECODE:    decode_reg    <= wr_frame.data;
                ADDR_INTENSITY: intensity_reg <= wr_frame.data[3:0];
                ADDR_SCANLIM:   scan_reg      <= wr_frame.data[2:0];
                ADDR_SHUTDOWN:  shutdown_reg  <= wr_frame.data[0];
                ADDR_TEST:      test_reg      <= wr_frame.data[0];
                default:        ;  // no-op, digits, 0xD and 0xE
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Segment output
    // ------------------------------------------------------------------
`ifdef MAX7219_RX_CODEB_EN
    logic [63:0] dec_seg;
    logic [63:0] seg_reg;

    for (gi = 0; gi < 8; gi++) begin : g_dec
        max7219_codeb_dec u_dec (
            .code      (digits[8*gi +: 8]),
            .decode_en (decode_reg[gi]),
            .seg       (dec_seg[8*gi +: 8])
        );
    end

    // Register the decoded patterns; seg_out lags digits by one clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= '0;
        end else begin
            seg_reg <= dec_seg;
        end
    end

    assign seg_out = seg_reg;
`else
    assign seg_out = digits;
`endif

    assign s_dout       = dout_reg;
    assign frame_valid  = frame_valid_reg;
    assign frame_err    = frame_err_reg;
    assign frame_addr   = frame_addr_reg;
    assign frame_data   = frame_data_reg;
    assign decode_mode  = decode_reg;
    assign intensity    = intensity_reg;
    assign scan_limit   = scan_reg;
    assign shutdown_n   = shutdown_reg;
    assign display_test = test_reg;

endmodule

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
- Serial responder for the MAX7219/7221 16-bit frame protocol. It is the receiving end of the frames our display driver transmits.
- Oversamples LOAD/CS, CLK and DIN on the system clock, deserialises each frame, and applies it to a shadow copy of the MAX7219 register file.
- Exposes the register contents and frame events as parallel outputs. Used as an on-chip display emulator and loopback checker for the display path.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each of the three serial inputs (≥2).
- CNT_W, 5, width of the saturating bit counter (must hold ≥17).

Ports:
- clk  input  1  system clock; must be ≥4× the serial clock rate.
- rst  input  1  asynchronous, active-high reset.
- s_cs  input  1  LOAD/CS; low = frame in progress, rising edge = latch.
- s_sck  input  1  serial clock; data sampled on its rising edge.
- s_din  input  1  serial data, MSB first.
- s_dout  output  1  daisy-chain output: bit 15 of the shift register, updated on s_sck falling edge.
- frame_valid  output  1  one-clk pulse when a complete frame is latched.
- frame_err  output  1  one-clk pulse when s_cs rises after fewer than 16 bits.
- frame_addr  output  4  address nibble (bits 11:8) of the last valid frame.
- frame_data  output  8  data byte (bits 7:0) of the last valid frame.
- digits  output  64  digit registers 1..8; digit n occupies [8n-1:8n-8].
- decode_mode  output  8  register 0x9.
- intensity  output  4  register 0xA, bits [3:0].
- scan_limit  output  3  register 0xB, bits [2:0].
- shutdown_n  output  1  register 0xC, bit 0 (1 = normal operation).
- display_test  output  1  register 0xF, bit 0.
- seg_out  output  64  per-digit segment pattern (see Optional Feature).

Behaviour:
- Reset: all outputs 0. Shift register and counter 0. Synchronisers preset to s_cs=1, s_sck=0. The block therefore powers up in shutdown, matching the device.
- Input path: each input passes through SYNC_STAGES flops, then one edge-detect register. An edge on a pin acts at clk cycle SYNC_STAGES+1 after it.
- Shifting: on each detected s_sck rising edge while synchronised s_cs=0:
  - shift register becomes {sr[14:0], din_sync};
  - bit counter increments, saturating at all-ones.
- s_sck edges while s_cs=1 are ignored.
- s_dout: registered; takes sr[15] on each detected s_sck falling edge while s_cs=0; holds otherwise. It therefore presents the bit 16 clocks older, giving daisy-chain behaviour.
- Latch: on detected s_cs rising edge:
  - if counter ≥16: frame_valid pulses the next cycle. frame_addr=sr[11:8] and frame_data=sr[7:0] update in that same cycle, together with the target register. Only the last 16 bits count; bits 15:12 are don't-care.
  - if 0 < counter < 16: frame_err pulses; no register changes.
  - if counter = 0: nothing happens.
  - In all cases the counter clears.
- s_cs falling edge: counter clears. The shift register keeps its contents.
- Address map:
  - 0x0: no-op; frame_valid still pulses.
  - 0x1–0x8: digit 0–7.
  - 0x9: decode_mode.
  - 0xA: intensity.
  - 0xB: scan_limit.
  - 0xC: shutdown_n.
  - 0xF: display_test.
  - 0xD, 0xE: ignored; frame_valid still pulses.
- Simultaneous s_cs rise and s_sck rise in the same cycle: the latch wins and the sck edge is dropped. The frame uses the 16 bits already shifted.
- Register writes are accepted while shutdown_n=0 or display_test=1; these bits are status only.
- Reset asserted mid-frame: the partial frame is discarded with no pulse. Registers return to 0.

Optional Feature:
- Macro: MAX7219_RX_CODEB_EN.
- Defined: seg_out[n] is the Code-B decode of digit n when decode_mode[n]=1; otherwise it is the raw digit byte.
- Code-B mapping (bit 7 = DP, passed through):
  - 0–9 are the digits;
  - 0xA = '-', 0xB = 'E', 0xC = 'H', 0xD = 'L', 0xE = 'P', 0xF = blank.
- Segment byte order is DP,A,B,C,D,E,F,G.
- seg_out is registered and lags digits by 1 clk.
- Undefined: seg_out is a direct copy of digits with no added latency.

Decomposition:
- Shared package max7219_pkg holds:
  - address constants (ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN, ADDR_TEST);
  - the Code-B segment constant table.
- These are shared with the transmit-side code module.
- One sub-module: max7219_codeb_dec, a combinational byte-to-segment decoder. It is instantiated 8× only under the macro.

Test Plan:
- Frame 0x0C01 (≥4 clk per sck phase) → frame_valid pulse; frame_addr=0xC, frame_data=0x01; shutdown_n=1. All other outputs unchanged.
- Frame 0x0A0F then 0x0B07 → intensity=0xF, scan_limit=7; two frame_valid pulses.
- 10 bits then s_cs rise → frame_err pulse, no frame_valid, registers unchanged.
- 24 bits 0xAA_0155 in one frame → digit 0 (digits[7:0])=0x55. s_dout reproduces the first 16 bits (0xAA01) delayed by 16 sck.
- s_cs rise and s_sck rise in the same sampled cycle after 16 bits of 0x0305 → digit 2 (digits[23:16])=0x05; the extra sck edge is ignored.
- With MAX7219_RX_CODEB_EN: 0x0901, then 0x0185 → seg_out[7:0]=0xDB ('5' with DP). Without the macro: seg_out[7:0]=0x85. Also assert rst mid-frame → all outputs 0 and no pulse.
